// File: rtl/m_ext_pkg.sv
// Shared constants and types for the M-extension PCPI divide sequencer.
package m_ext_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   typedef enum logic [2:0] {
      F3_DIV  = 3'b100,
      F3_DIVU = 3'b101,
      F3_REM  = 3'b110,
      F3_REMU = 3'b111
   } div_funct3_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      RESP  = 2'd2,
      DRAIN = 2'd3
   } div_ctrl_state_e;

   typedef struct packed {
      logic hit;
      logic is_unsigned;
      logic is_rem;
   } div_decode_t;

endpackage

// File: rtl/div_insn_decode.sv
// Combinational decode of DIV/DIVU/REM/REMU from a 32-bit instruction word.
module div_insn_decode
   import m_ext_pkg::*;
(
   input  logic [31:0] insn,
   output div_decode_t dec
);

   // Register-number fields play no part in the decode.
   logic unused_insn_bits;
   assign unused_insn_bits = ^{insn[24:15], insn[11:7]};

   always_comb begin
      dec.hit         = (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV) && insn[14];
      dec.is_unsigned = insn[12];
      dec.is_rem      = insn[13];
   end

endmodule

// File: rtl/pcpi_div_ctrl.sv
// PCPI sequencer for the shared serial divider: decode, operand capture, start/done handshake.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module pcpi_div_ctrl
   import m_ext_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pcpi_valid,
   input  logic [31:0]      pcpi_insn,
   input  logic [WIDTH-1:0] pcpi_rs1,
   input  logic [WIDTH-1:0] pcpi_rs2,
   output logic             pcpi_wr,
   output logic [WIDTH-1:0] pcpi_rd,
   output logic             pcpi_wait,
   output logic             pcpi_ready,
   output logic             div_start,
   output logic             div_unsigned,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r,
   input  logic             div_done
);

   div_ctrl_state_e  state;
   div_decode_t      dec;
   logic             wait_q;
   logic             rem_q;
   logic             uns_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] rd_q;
   logic             cache_hit;
   logic [WIDTH-1:0] cache_res;

   div_insn_decode u_decode (
      .insn (pcpi_insn),
      .dec  (dec)
   );

`ifdef DIV_RESULT_CACHE_EN
   logic             c_valid;
   logic             c_uns;
   logic [WIDTH-1:0] c_a;
   logic [WIDTH-1:0] c_b;
   logic [WIDTH-1:0] c_q;
   logic [WIDTH-1:0] c_r;

   assign cache_hit = c_valid && (pcpi_rs1 == c_a) && (pcpi_rs2 == c_b) && (dec.is_unsigned == c_uns);
   assign cache_res = dec.is_rem ? c_r : c_q;

   // NOTE: the cache data is reset along with its valid bit so that a post-reset
   // state is fully defined; only valid actually gates use of the entry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         c_valid <= 1'b0;
         c_uns   <= 1'b0;
         c_a     <= '0;
         c_b     <= '0;
         c_q     <= '0;
         c_r     <= '0;
      end else if (state == BUSY && div_done) begin
         c_valid <= 1'b1;
         c_uns   <= uns_q;
         c_a     <= a_q;
         c_b     <= b_q;
         c_q     <= div_q;
         c_r     <= div_r;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign cache_res = '0;
`endif

   // NOTE: all state updates use non-blocking assignments so every register samples
   // the values from before this edge, independent of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         wait_q <= 1'b0;
         rem_q  <= 1'b0;
         uns_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         rd_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pcpi_valid && dec.hit) begin
                  a_q   <= pcpi_rs1;
                  b_q   <= pcpi_rs2;
                  uns_q <= dec.is_unsigned;
                  rem_q <= dec.is_rem;
                  if (cache_hit) begin
                     rd_q  <= cache_res;
                     state <= RESP;
                  end else begin
                     wait_q <= 1'b1;
                     state  <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (div_done) begin
                  rd_q   <= rem_q ? div_r : div_q;
                  wait_q <= 1'b0;
                  state  <= RESP;
               end
            end
            RESP: state <= DRAIN;
            // Hold off re-accepting until the divider has dropped done, so the
            // still-asserted pcpi_valid of the finished instruction is not taken again.
            DRAIN: begin
               if (!div_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign div_start    = (state == BUSY);
   assign pcpi_ready   = (state == RESP);
   assign pcpi_wr      = (state == RESP);
   assign pcpi_wait    = wait_q;
   assign pcpi_rd      = rd_q;
   assign div_a        = a_q;
   assign div_b        = b_q;
   assign div_unsigned = uns_q;

endmodule

// File: tb/tb_pcpi_div_ctrl.sv
// Self-checking bench for pcpi_div_ctrl with a behavioural serial-divider model.
// Cache-specific expectations are active when DIV_RESULT_CACHE_EN is defined.
module tb_pcpi_div_ctrl;
   import m_ext_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        pcpi_valid = 1'b0;
   logic [31:0] pcpi_insn = '0;
   logic [31:0] pcpi_rs1 = '0;
   logic [31:0] pcpi_rs2 = '0;
   logic        pcpi_wr, pcpi_wait, pcpi_ready;
   logic [31:0] pcpi_rd;
   logic        div_start, div_unsigned;
   logic [31:0] div_a, div_b;
   logic [31:0] div_q, div_r;
   logic        div_done;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pcpi_div_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .resetn(resetn),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
      .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
      .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
      .div_start(div_start), .div_unsigned(div_unsigned),
      .div_a(div_a), .div_b(div_b),
      .div_q(div_q), .div_r(div_r), .div_done(div_done)
   );

   // RISC-V M-extension division semantics, including the divide-by-zero and overflow rules.
   function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b, input logic uns);
      if (b == 32'd0) return 32'hFFFF_FFFF;
      if (uns) return a / b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
      return $signed(a) / $signed(b);
   endfunction

   function automatic logic [31:0] model_r(input logic [31:0] a, input logic [31:0] b, input logic uns);
      if (b == 32'd0) return a;
      if (uns) return a % b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
      return $signed(a) % $signed(b);
   endfunction

   function automatic logic [31:0] mk_insn(input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] opc);
      return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Serial divider stand-in: random latency, junk outputs until done, done may linger after start drops.
   int lat_cfg = 0;
   int linger_cfg = 0;
   int d_cnt;
   int d_ling;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_done <= 1'b0;
         div_q    <= '0;
         div_r    <= '0;
         d_cnt    <= 0;
         d_ling   <= 0;
      end else if (div_start) begin
         if (!div_done) begin
            if (d_cnt >= lat_cfg) begin
               div_done <= 1'b1;
               div_q    <= model_q(div_a, div_b, div_unsigned);
               div_r    <= model_r(div_a, div_b, div_unsigned);
               d_ling   <= linger_cfg;
            end else begin
               d_cnt <= d_cnt + 1;
               div_q <= $urandom;
               div_r <= $urandom;
            end
         end
      end else begin
         d_cnt <= 0;
         if (div_done) begin
            if (d_ling == 0) div_done <= 1'b0;
            else d_ling <= d_ling - 1;
         end
      end
   end

   // Reference view of the one-entry cache: operands of the last divide that ran on the divider.
   bit          mc_valid = 1'b0;
   logic [31:0] mc_a, mc_b;
   logic        mc_uns;

   task automatic run_op(input string name, input logic [31:0] insn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_rd,
                         input bit hold_drain, input bit drop_early);
      logic uns;
      bit   exp_cached;
      int   starts, first_done, ready_n, wait_err, stable_err, extra;
      logic prev_start;
      uns = insn[12];
      exp_cached = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
      exp_cached = mc_valid && a == mc_a && b == mc_b && uns == mc_uns;
`endif
      lat_cfg    = $urandom_range(0, 6);
      linger_cfg = $urandom_range(0, 2);
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = insn;
      pcpi_rs1   = a;
      pcpi_rs2   = b;
      starts = 0; first_done = -1; ready_n = -1; wait_err = 0; stable_err = 0; prev_start = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (n == 2) begin
            pcpi_rs1 = $urandom;
            pcpi_rs2 = $urandom;
            if (drop_early) pcpi_valid = 1'b0;
         end
         if (div_start && !prev_start) starts++;
         prev_start = div_start;
         if (div_start && (div_a !== a || div_b !== b || div_unsigned !== uns)) stable_err++;
         if (div_done && first_done < 0) first_done = n;
         if (pcpi_ready) begin
            ready_n = n;
            break;
         end
         if (!pcpi_wait || pcpi_wr) wait_err++;
      end
      check({name, " ready_seen"}, ready_n >= 0, 1);
      if (ready_n < 0) begin
         pcpi_valid = 1'b0;
         return;
      end
      check({name, " rd"}, pcpi_rd, exp_rd);
      check({name, " wr_with_ready"}, pcpi_wr, 1);
      check({name, " wait_low_at_ready"}, pcpi_wait, 0);
      if (exp_cached) begin
         check({name, " cached_latency"}, ready_n, 1);
         check({name, " cached_no_start"}, starts, 0);
      end else begin
         check({name, " start_pulses"}, starts, 1);
         check({name, " ready_after_done"}, ready_n, first_done + 1);
         mc_valid = 1'b1;
         mc_a = a;
         mc_b = b;
         mc_uns = uns;
      end
      check({name, " operands_stable"}, stable_err, 0);
      check({name, " wait_profile"}, wait_err, 0);
      extra = 0;
      if (hold_drain) begin
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pcpi_ready || pcpi_wait) extra++;
            if (!div_done) break;
         end
      end
      @(negedge clk);
      pcpi_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (pcpi_ready || pcpi_wait) extra++;
         @(negedge clk);
      end
      check({name, " no_reaccept"}, extra, 0);
   endtask

   task automatic ignored_insn(input string name, input logic [31:0] insn);
      int hits;
      hits = 0;
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = insn;
      pcpi_rs1   = $urandom;
      pcpi_rs2   = $urandom;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (pcpi_wait || pcpi_ready || pcpi_wr || div_start) hits++;
      end
      pcpi_valid = 1'b0;
      check({name, " ignored"}, hits, 0);
   endtask

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t tv[10];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ra, rb, rexp;
      logic [2:0]  f3;
      int          mode;

      tv[0] = '{"div_100_7",      3'b100, 32'd100,         32'd7,           32'd14};
      tv[1] = '{"rem_100_7",      3'b110, 32'd100,         32'd7,           32'd2};
      tv[2] = '{"remu_ffff_10",   3'b111, 32'hFFFF_FFFF,   32'h10,          32'hF};
      tv[3] = '{"div_m7_2",       3'b100, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD};
      tv[4] = '{"div_by_zero",    3'b100, 32'd12345,       32'd0,           32'hFFFF_FFFF};
      tv[5] = '{"div_overflow",   3'b100, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000};
      tv[6] = '{"rem_m7_2",       3'b110, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF};
      tv[7] = '{"divu_big",       3'b101, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0};
      tv[8] = '{"rem_overflow",   3'b110, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0};
      tv[9] = '{"remu_by_zero",   3'b111, 32'd5,           32'd0,           32'd5};

      repeat (3) @(negedge clk);
      check("reset_outputs", {pcpi_wait, pcpi_ready, pcpi_wr, div_start, div_unsigned, pcpi_rd, div_a, div_b}, '0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", {pcpi_wait, pcpi_ready, div_start}, '0);

      // Directed vectors: first one holds valid through DRAIN, fourth drops valid mid-divide.
      for (int i = 0; i < 10; i++)
         run_op(tv[i].name, mk_insn(tv[i].f3, F7_MULDIV, OPC_OP), tv[i].a, tv[i].b, tv[i].exp,
                i == 0, i == 3);

      ignored_insn("mul",    mk_insn(3'b000, F7_MULDIV, OPC_OP));
      ignored_insn("op_imm", mk_insn(3'b100, F7_MULDIV, 7'b0010011));
      ignored_insn("xor",    mk_insn(3'b100, 7'b0000000, OPC_OP));

      // Randomized operations checked against the arithmetic reference.
      ra = 32'd1;
      rb = 32'd1;
      for (int i = 0; i < 40; i++) begin
         f3   = 3'b100 | 3'($urandom_range(0, 3));
         mode = $urandom_range(0, 7);
         case (mode)
            0: begin ra = $urandom; rb = 32'd0; end
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: ;
            3: begin ra = $urandom; rb = 32'($urandom_range(1, 15)); end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         rexp = f3[1] ? model_r(ra, rb, f3[0]) : model_q(ra, rb, f3[0]);
         run_op($sformatf("rand%0d", i), mk_insn(f3, F7_MULDIV, OPC_OP), ra, rb, rexp,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a long divide abandons it and clears everything.
      run_op("pre_reset_div", mk_insn(3'b100, F7_MULDIV, OPC_OP), 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
      lat_cfg = 30;
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = mk_insn(3'b101, F7_MULDIV, OPC_OP);
      pcpi_rs1   = 32'd1000;
      pcpi_rs2   = 32'd3;
      repeat (3) @(negedge clk);
      check("busy_before_reset", {pcpi_wait, div_start, div_unsigned}, 3'b111);
      resetn = 1'b0;
      #1;
      check("mid_busy_reset_outputs",
            {pcpi_wait, pcpi_ready, pcpi_wr, div_start, div_unsigned, pcpi_rd, div_a, div_b}, '0);
      pcpi_valid = 1'b0;
      mc_valid   = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      run_op("post_reset_div", mk_insn(3'b100, F7_MULDIV, OPC_OP), 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
      run_op("post_reset_rem", mk_insn(3'b110, F7_MULDIV, OPC_OP), 32'd100, 32'd7, 32'd2, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
